// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the async FIFO and its UART drain.
// master = the consumer issuing the read strobe, slave = the FIFO read side.
interface fifo_uart_tx_if #(
   parameter int DSIZE = 8
);
   logic [DSIZE-1:0] rdata;
   logic             empty;
   logic             rinc;

   modport master (
      input  rdata,
      input  empty,
      output rinc
   );

   modport slave (
      output rdata,
      output empty,
      input  rinc
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and serializes them as UART frames: start, DSIZE data bits LSB first, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
   parameter int DSIZE   = 8,
   parameter int CLK_DIV = 434
) (
   input  logic                 rclk,
   input  logic                 rst,
   fifo_uart_tx_if.master       rd,
   output logic                 txd,
   output logic                 busy
);

   localparam int              BW        = (DSIZE > 1) ? $clog2(DSIZE) : 1;
   localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST  = BW'(DSIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state, state_n;
   logic [15:0]      baud_cnt, baud_n;
   logic [BW-1:0]    bit_cnt, bit_n;
   logic [DSIZE-1:0] shreg, shreg_n;
   logic             txd_n, busy_n;
   logic             rinc, rinc_n;
   logic             load;
   logic             baud_done;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             par, par_n;
`endif

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign rd.rinc   = rinc;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt + 16'd1;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      txd_n   = txd;
      busy_n  = busy;
      rinc_n  = 1'b0;
      load    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_n   = par;
`endif

      unique case (state)
         IDLE: begin
            baud_n = '0;
            txd_n  = 1'b1;
            busy_n = 1'b0;
            load   = !rd.empty;
         end
         START: begin
            if (baud_done) begin
               baud_n  = '0;
               bit_n   = '0;
               txd_n   = shreg[0];
               state_n = DATA;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_n = '0;
               if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_n = PARITY;
                  txd_n   = par;
`else
                  state_n = STOP;
                  txd_n   = 1'b1;
`endif
               end else begin
                  bit_n   = bit_cnt + 1'b1;
                  shreg_n = shreg >> 1;
                  txd_n   = shreg_n[0];
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            if (baud_done) begin
               baud_n  = '0;
               state_n = STOP;
               txd_n   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_done) begin
               baud_n = '0;
               // A waiting word starts its frame with no idle gap.
               if (!rd.empty) begin
                  load = 1'b1;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  txd_n   = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (load) begin
         shreg_n = rd.rdata;
         rinc_n  = 1'b1;
         txd_n   = 1'b0;
         busy_n  = 1'b1;
         baud_n  = '0;
         bit_n   = '0;
         state_n = START;
`ifdef FIFO_UART_TX_PARITY_EN
         par_n   = ^rd.rdata;
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above.
   always_ff @(posedge rclk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         rinc     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= shreg_n;
         txd      <= txd_n;
         busy     <= busy_n;
         rinc     <= rinc_n;
`ifdef FIFO_UART_TX_PARITY_EN
         par      <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLK_DIV=4; a queue stands in for the FIFO read port.
module tb_fifo_uart_tx;

   localparam int DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB  = 11;
`else
   localparam int NB  = 10;
`endif

   logic rclk;
   logic rst;
   logic txd;
   logic busy;

   fifo_uart_tx_if #(.DSIZE(8)) fif ();

   fifo_uart_tx #(.DSIZE(8), .CLK_DIV(DIV)) dut (
      .rclk (rclk),
      .rst  (rst),
      .rd   (fif),
      .txd  (txd),
      .busy (busy)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int n_cmp = 0;
   int n_err = 0;
   int rinc_cnt = 0;
   int busy_cnt = 0;
   int underflow_cnt = 0;
   logic s_txd, s_rinc, s_busy;
   logic [7:0] q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      fif.empty = (q.size() == 0);
      fif.rdata = (q.size() == 0) ? 8'h00 : q[0];
   endtask

   // Advance one cycle, sample outputs at the falling edge, service the pop.
   task automatic tick();
      @(negedge rclk);
      s_txd  = txd;
      s_rinc = fif.rinc;
      s_busy = busy;
      if (s_busy) busy_cnt++;
      if (s_rinc) begin
         rinc_cnt++;
         if (q.size() == 0) underflow_cnt++;
         else void'(q.pop_front());
      end
      refresh();
   endtask

   task automatic wait_start(input string tag);
      int waited = 0;
      do begin
         tick();
         waited++;
      end while (s_txd !== 1'b0 && waited < 20);
      check({tag, "_start_lat"}, waited, 1);
      check({tag, "_rinc_lat"}, {31'd0, s_rinc}, 1);
   endtask

   // Checks every bit period of one frame; the first sample may already be taken.
   task automatic expect_frame(input logic [7:0] w, input string tag, input bit first_taken);
      logic [NB-1:0] bits;
      logic [DIV-1:0] v;
`ifdef FIFO_UART_TX_PARITY_EN
      bits = {1'b1, ^w, w, 1'b0};
`else
      bits = {1'b1, w, 1'b0};
`endif
      for (int b = 0; b < NB; b++) begin
         for (int c = 0; c < DIV; c++) begin
            if (!(b == 0 && c == 0 && first_taken)) tick();
            v[c] = s_txd;
         end
         check($sformatf("%s_b%0d", tag, b), {28'd0, v}, {28'd0, {DIV{bits[b]}}});
      end
   endtask

   initial begin
      rst = 1'b1;
      q.push_back(8'hFF);
      refresh();

      // Reset held with a word waiting: no pop, idle outputs.
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_txd%0d", i), {31'd0, s_txd}, 1);
         check($sformatf("rst_rinc%0d", i), {31'd0, s_rinc}, 0);
         check($sformatf("rst_busy%0d", i), {31'd0, s_busy}, 0);
      end
      q.delete();
      refresh();
      @(negedge rclk);
      rst = 1'b0;

      // Empty FIFO for 1000 cycles.
      begin
         int low_cnt = 0;
         rinc_cnt = 0;
         busy_cnt = 0;
         for (int i = 0; i < 1000; i++) begin
            tick();
            if (s_txd !== 1'b1) low_cnt++;
         end
         check("empty_rinc", rinc_cnt, 0);
         check("empty_txd_low", low_cnt, 0);
         check("empty_busy", busy_cnt, 0);
      end

      // Single word 0x55: txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles.
      rinc_cnt = 0;
      busy_cnt = 0;
      q.push_back(8'h55);
      refresh();
      wait_start("w55");
      expect_frame(8'h55, "w55", 1'b1);
      tick();
      check("w55_busy_end", {31'd0, s_busy}, 0);
      check("w55_txd_idle", {31'd0, s_txd}, 1);
      check("w55_rinc_cnt", rinc_cnt, 1);
      check("w55_busy_cnt", busy_cnt, NB * DIV);

      // Back-to-back 0xA5, 0x3C: second start right after first stop.
      repeat (3) tick();
      rinc_cnt = 0;
      busy_cnt = 0;
      q.push_back(8'hA5);
      q.push_back(8'h3C);
      refresh();
      wait_start("b2b");
      expect_frame(8'hA5, "b2b_a5", 1'b1);
      expect_frame(8'h3C, "b2b_3c", 1'b0);
      tick();
      check("b2b_busy_end", {31'd0, s_busy}, 0);
      check("b2b_rinc_cnt", rinc_cnt, 2);
      check("b2b_busy_cnt", busy_cnt, 2 * NB * DIV);

      // Reset during data bit 3 of 0x96 (bit3 = 0), then 0x5A follows.
      repeat (3) tick();
      rinc_cnt = 0;
      q.push_back(8'h96);
      q.push_back(8'h5A);
      refresh();
      wait_start("mid");
      repeat (4 * DIV) tick();
      check("mid_pre_rst_txd", {31'd0, s_txd}, 0);
      rst = 1'b1;
      tick();
      check("mid_rst_txd", {31'd0, s_txd}, 1);
      check("mid_rst_busy", {31'd0, s_busy}, 0);
      check("mid_rst_rinc", {31'd0, s_rinc}, 0);
      rst = 1'b0;
      wait_start("mid_next");
      expect_frame(8'h5A, "mid_5a", 1'b1);
      tick();
      check("mid_rinc_cnt", rinc_cnt, 2);
      check("mid_q_left", q.size(), 0);

`ifdef FIFO_UART_TX_PARITY_EN
      // Parity: 0x07 -> 1, 0x03 -> 0; frame is 11 bit periods.
      repeat (3) tick();
      busy_cnt = 0;
      q.push_back(8'h07);
      refresh();
      wait_start("p07");
      expect_frame(8'h07, "p07", 1'b1);
      tick();
      check("p07_busy_cnt", busy_cnt, 11 * DIV);
      busy_cnt = 0;
      q.push_back(8'h03);
      refresh();
      wait_start("p03");
      expect_frame(8'h03, "p03", 1'b1);
      tick();
      check("p03_busy_cnt", busy_cnt, 11 * DIV);
`endif

      check("pop_underflow", underflow_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
